vga_fill_engine: RTL and testbench

Rectangle-fill controller for the 80x60 VGA framebuffer write port. It accepts one fill command at a time over a valid/ready handshake and sequences single-pixel framebuffer writes in raster order. It also arbitrates the write port against direct CPU pixel writes from the MMIO decode, with the CPU always winning. It sits between the IOBUS register decode and the framebuffer driver's WA/WD/WE inputs.

---
 rtl/vga_fb_pkg.sv | 22 ++
 rtl/vga_xy_counter.sv | 68 ++++++
 rtl/vga_fill_engine.sv | 127 ++++++++++++
 tb/tb_vga_fill_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, fill FSM state type and address packing for the 80x60 framebuffer.
// Imported by the fill engine and its raster counter.
package vga_fb_pkg;

  localparam int X_BITS    = 7;
  localparam int Y_BITS    = 6;
  localparam int FB_W      = 80;
  localparam int FB_H      = 60;
  localparam int ADDR_BITS = X_BITS + Y_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } fill_state_t;

  function automatic logic [ADDR_BITS-1:0] fb_addr(input logic [X_BITS-1:0] x,
                                                   input logic [Y_BITS-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_xy_counter.sv
// Raster-order x/y walker over a loaded rectangle [x0,x_end) x [y0,y_end).
// `last` flags the bottom-right pixel of the rectangle.
module vga_xy_counter
  import vga_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [X_BITS-1:0] x0,
  input  logic [Y_BITS-1:0] y0,
  input  logic [X_BITS-1:0] x_end,
  input  logic [Y_BITS-1:0] y_end,
  input  logic              advance,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              last
);

  logic [X_BITS-1:0] x_q, x_d, x0_q, x0_d, x_end_q, x_end_d;
  logic [Y_BITS-1:0] y_q, y_d, y_end_q, y_end_d;
  logic              row_end;

  assign row_end = (x_q == x_end_q - X_BITS'(1));
  assign last    = row_end && (y_q == y_end_q - Y_BITS'(1));
  assign x       = x_q;
  assign y       = y_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    if (load) begin
      x_d     = x0;
      y_d     = y0;
      x0_d    = x0;
      x_end_d = x_end;
      y_end_d = y_end;
    end else if (advance) begin
      if (row_end) begin
        x_d = x0_q;
        y_d = y_q + Y_BITS'(1);
      end else begin
        x_d = x_q + X_BITS'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
    end
  end

endmodule

// File: rtl/vga_fill_engine.sv
// Rectangle-fill controller for the framebuffer write port; direct CPU pixel
// writes always win the port and merely stall an active fill.
module vga_fill_engine
  import vga_fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_wa,
  input  logic [7:0]           cpu_wd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [X_BITS-1:0]    cmd_x0,
  input  logic [Y_BITS-1:0]    cmd_y0,
  input  logic [X_BITS-1:0]    cmd_w,
  input  logic [Y_BITS-1:0]    cmd_h,
  input  logic [7:0]           cmd_color,
  output logic                 fb_we,
  output logic [ADDR_BITS-1:0] fb_wa,
  output logic [7:0]           fb_wd,
  output logic                 busy,
  output logic                 done
);

  fill_state_t          state_q, state_d;
  logic [7:0]           color_q, color_d;
  logic                 fill_done_q, fill_done_d;
  logic                 fb_we_q, fb_we_d;
  logic [ADDR_BITS-1:0] fb_wa_q, fb_wa_d;
  logic [7:0]           fb_wd_q, fb_wd_d;

  logic [X_BITS:0]      x_sum;
  logic [Y_BITS:0]      y_sum;
  logic [X_BITS-1:0]    x_end, cur_x;
  logic [Y_BITS-1:0]    y_end, cur_y;
  logic                 accept, degenerate, load, advance, last_pix;

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign accept     = cmd_valid && cmd_ready;

  assign x_sum      = {1'b0, cmd_x0} + {1'b0, cmd_w};
  assign y_sum      = {1'b0, cmd_y0} + {1'b0, cmd_h};
  assign x_end      = (x_sum > (X_BITS+1)'(FB_W)) ? X_BITS'(FB_W) : x_sum[X_BITS-1:0];
  assign y_end      = (y_sum > (Y_BITS+1)'(FB_H)) ? Y_BITS'(FB_H) : y_sum[Y_BITS-1:0];
  assign degenerate = (cmd_w == '0) || (cmd_h == '0) ||
                      (cmd_x0 >= X_BITS'(FB_W)) || (cmd_y0 >= Y_BITS'(FB_H));
  assign load       = accept && !degenerate;

  // fill_done_q marks the cycle after the last pixel was issued, so DONE
  // follows the final registered write rather than overlapping it.
  assign advance    = (state_q == FILL) && !fill_done_q && !cpu_we;

  vga_xy_counter u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .x0      (cmd_x0),
    .y0      (cmd_y0),
    .x_end   (x_end),
    .y_end   (y_end),
    .advance (advance),
    .x       (cur_x),
    .y       (cur_y),
    .last    (last_pix)
  );

  always_comb begin
    state_d     = state_q;
    color_d     = color_q;
    fill_done_d = 1'b0;
    fb_we_d     = 1'b0;
    fb_wa_d     = fb_wa_q;
    fb_wd_d     = fb_wd_q;

    if (cpu_we) begin
      fb_we_d = 1'b1;
      fb_wa_d = cpu_wa;
      fb_wd_d = cpu_wd;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          color_d = cmd_color;
          state_d = degenerate ? FINISH : FILL;
        end
      end
      FILL: begin
        if (fill_done_q) begin
          state_d = FINISH;
        end else if (!cpu_we) begin
          fb_we_d     = 1'b1;
          fb_wa_d     = fb_addr(cur_x, cur_y);
          fb_wd_d     = color_q;
          fill_done_d = last_pix;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      color_q     <= '0;
      fill_done_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_wa_q     <= '0;
      fb_wd_q     <= '0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      fill_done_q <= fill_done_d;
      fb_we_q     <= fb_we_d;
      fb_wa_q     <= fb_wa_d;
      fb_wd_q     <= fb_wd_d;
    end
  end

  assign fb_we = fb_we_q;
  assign fb_wa = fb_wa_q;
  assign fb_wd = fb_wd_q;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Scoreboard bench for vga_fill_engine: stimulus queues expected writes/DONE,
// a negedge monitor pops and compares every FB_WE and DONE the DUT presents.
module tb_vga_fill_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_wa = '0;
  logic [7:0]  cpu_wd = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x0 = '0;
  logic [5:0]  cmd_y0 = '0;
  logic [6:0]  cmd_w = '0;
  logic [5:0]  cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic        fb_we;
  logic [12:0] fb_wa;
  logic [7:0]  fb_wd;
  logic        busy;
  logic        done;

  vga_fill_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_we    (cpu_we),
    .cpu_wa    (cpu_wa),
    .cpu_wd    (cpu_wd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .fb_we     (fb_we),
    .fb_wa     (fb_wa),
    .fb_wd     (fb_wd),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [12:0] wa;
    logic [7:0]  wd;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic note_extra(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event with value %0d, expected none", name, act);
  endtask

  task automatic push_wr(input logic [12:0] wa, input logic [7:0] wd);
    exp_q.push_back('{is_done: 1'b0, wa: wa, wd: wd});
  endtask

  task automatic push_done();
    exp_q.push_back('{is_done: 1'b1, wa: '0, wd: '0});
  endtask

  // Monitor: every visible write or DONE must match the head of the queue.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (fb_we === 1'b1) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          note_extra("wr_unexpected", {19'd0, fb_wa});
        end else begin
          e = exp_q.pop_front();
          check("wr_kind", {31'd0, e.is_done}, 32'd0);
          check("wr_addr", {19'd0, fb_wa}, {19'd0, e.wa});
          check("wr_data", {24'd0, fb_wd}, {24'd0, e.wd});
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          note_extra("done_unexpected", 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", {31'd0, e.is_done}, 32'd1);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_ready_wait"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one command and verify DONE lands exp_k cycles after the handshake
  // cycle, with CMD_READY low during DONE and high the cycle after.
  task automatic run_cmd(input logic [6:0] x0, input logic [5:0] y0,
                         input logic [6:0] w, input logic [5:0] h,
                         input logic [7:0] color, input int exp_k,
                         input int cpu_k, input logic [12:0] cwa,
                         input logic [7:0] cwd, input bit hold_valid,
                         input string name);
    int k;
    bit seen;
    wait_ready(name);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) cmd_valid = 1'b0;
    k = 1;
    seen = 1'b0;
    while (k < exp_k + 20) begin
      cpu_we = (k == cpu_k);
      cpu_wa = cwa;
      cpu_wd = cwd;
      if (k == 1) check({name, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    cmd_valid = 1'b0;
    cpu_we = 1'b0;
    check({name, "_done_cycle"}, seen ? k : -1, exp_k);
    check({name, "_ready_in_done"}, {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check({name, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fb_we", {31'd0, fb_we}, 32'd0);
    check("rst_fb_wa", {19'd0, fb_wa}, 32'd0);
    check("rst_fb_wd", {24'd0, fb_wd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3x2 block at (2,3), no contention
    push_wr(13'd386, 8'hE0); push_wr(13'd387, 8'hE0); push_wr(13'd388, 8'hE0);
    push_wr(13'd514, 8'hE0); push_wr(13'd515, 8'hE0); push_wr(13'd516, 8'hE0);
    push_done();
    run_cmd(7'd2, 6'd3, 7'd3, 6'd2, 8'hE0, 8, 0, 13'd0, 8'h00, 1'b0, "normal");

    // Same block, CPU write in the second FILL cycle
    push_wr(13'd386, 8'hE0); push_wr(13'd100, 8'h1C); push_wr(13'd387, 8'hE0);
    push_wr(13'd388, 8'hE0); push_wr(13'd514, 8'hE0); push_wr(13'd515, 8'hE0);
    push_wr(13'd516, 8'hE0);
    push_done();
    run_cmd(7'd2, 6'd3, 7'd3, 6'd2, 8'hE0, 9, 2, 13'd100, 8'h1C, 1'b0, "contention");

    // Clipped at the bottom-right corner
    push_wr(13'd7630, 8'h1F); push_wr(13'd7631, 8'h1F);
    push_done();
    run_cmd(7'd78, 6'd59, 7'd5, 6'd4, 8'h1F, 4, 0, 13'd0, 8'h00, 1'b0, "clip");

    // Degenerate commands
    push_done();
    run_cmd(7'd5, 6'd5, 7'd0, 6'd3, 8'hFF, 1, 0, 13'd0, 8'h00, 1'b0, "deg_w0");
    push_done();
    run_cmd(7'd80, 6'd5, 7'd5, 6'd5, 8'hFF, 1, 0, 13'd0, 8'h00, 1'b0, "deg_x80");

    // Full screen with CMD_VALID held high throughout
    base = wr_seen;
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++)
        push_wr(13'(y * 128 + x), 8'h49);
    push_done();
    run_cmd(7'd0, 6'd0, 7'd80, 6'd60, 8'h49, 4802, 0, 13'd0, 8'h00, 1'b1, "full");
    check("full_wr_count", wr_seen - base, 32'd4800);
    check("full_last_wa", {19'd0, fb_wa}, 32'd7631);

    // Full screen aborted by reset after the 3rd write
    base = wr_seen;
    push_wr(13'd0, 8'h03); push_wr(13'd1, 8'h03); push_wr(13'd2, 8'h03);
    wait_ready("abort");
    cmd_x0 = 7'd0; cmd_y0 = 6'd0; cmd_w = 7'd80; cmd_h = 6'd60; cmd_color = 8'h03;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && wr_seen < base + 3; i++) begin
      @(negedge clk); #1;
    end
    check("abort_wr_before", wr_seen - base, 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort_fb_we", {31'd0, fb_we}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_wr_after", wr_seen - base, 32'd3);
    @(posedge clk); #1;

    // Normal command after reset release
    push_wr(13'd386, 8'h5A); push_wr(13'd387, 8'h5A); push_wr(13'd388, 8'h5A);
    push_wr(13'd514, 8'h5A); push_wr(13'd515, 8'h5A); push_wr(13'd516, 8'h5A);
    push_done();
    run_cmd(7'd2, 6'd3, 7'd3, 6'd2, 8'h5A, 8, 0, 13'd0, 8'h00, 1'b0, "post_reset");

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
